// File: rtl/core_pipe_exec_lsu.sv
// core_pipe_exec_lsu: EX-stage load/store unit driving a 64-bit req/gnt data memory port.
module core_pipe_exec_lsu #(
    parameter int XLEN = 64
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            lsu_valid,
    input  logic            lsu_load,
    input  logic            lsu_store,
    input  logic [1:0]      lsu_width,
    input  logic            lsu_signed,
    input  logic [XLEN-1:0] lsu_addr,
    input  logic [XLEN-1:0] lsu_wdata,
    input  logic            lsu_new_instr,
    input  logic            lsu_flush,
    output logic            lsu_ready,
    output logic            lsu_rd_wen,
    output logic [XLEN-1:0] lsu_rdata,
    output logic            lsu_trap,
    output logic [3:0]      lsu_trap_cause,
    output logic            dmem_req,
    output logic [63:0]     dmem_addr,
    output logic            dmem_wen,
    output logic [7:0]      dmem_strb,
    output logic [63:0]     dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_err,
    input  logic [63:0]     dmem_rdata
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    logic [1:0]      state;
    logic [63:0]     addr_q;
    logic [63:0]     wdata_q;
    logic            wen_q;
    logic [7:0]      strb_q;
    logic [1:0]      width_q;
    logic            signed_q;
    logic [2:0]      off_q;
    logic [XLEN-1:0] rdata_q;
    logic            trap_q;
    logic            rd_wen_q;
    logic [3:0]      cause_q;
    logic            mem_op;
    logic            misal;
    logic [63:0]     a64;
    logic [63:0]     w64;
    logic [7:0]      mask;
    logic [7:0]      strb_n;
    logic [63:0]     wdata_n;
    logic [63:0]     sh;
    logic [63:0]     ld_ext;
    always_comb begin
        mem_op  = lsu_valid && (lsu_load || lsu_store);
        a64     = 64'(lsu_addr);
        w64     = 64'(lsu_wdata);
        misal   = (lsu_width == 2'd1 && a64[0]) || (lsu_width == 2'd2 && |a64[1:0]) ||
                  (lsu_width == 2'd3 && |a64[2:0]);
        mask    = lsu_width == 2'd0 ? 8'h01 : lsu_width == 2'd1 ? 8'h03 :
                  lsu_width == 2'd2 ? 8'h0F : 8'hFF;
        strb_n  = lsu_store ? mask << a64[2:0] : 8'h00;
        wdata_n = lsu_width == 2'd0 ? {8{w64[7:0]}} : lsu_width == 2'd1 ? {4{w64[15:0]}} :
                  lsu_width == 2'd2 ? {2{w64[31:0]}} : w64;
        sh      = dmem_rdata >> {off_q, 3'b000};
        ld_ext  = width_q == 2'd0 ? {{56{signed_q & sh[7]}}, sh[7:0]} :
                  width_q == 2'd1 ? {{48{signed_q & sh[15]}}, sh[15:0]} :
                  width_q == 2'd2 ? {{32{signed_q & sh[31]}}, sh[31:0]} : sh;
    end
    assign dmem_req       = state == REQ || state == DRAIN;
    assign dmem_addr      = addr_q;
    assign dmem_wen       = dmem_req && wen_q;
    assign dmem_strb      = dmem_req ? strb_q : 8'h00;
    assign dmem_wdata     = wdata_q;
    assign lsu_ready      = (state == IDLE && !mem_op) || state == DONE;
    assign lsu_rd_wen     = rd_wen_q;
    assign lsu_rdata      = rdata_q;
    assign lsu_trap       = trap_q;
    assign lsu_trap_cause = cause_q;
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state    <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wen_q    <= 1'b0;
            strb_q   <= '0;
            width_q  <= '0;
            signed_q <= 1'b0;
            off_q    <= '0;
            rdata_q  <= '0;
            trap_q   <= 1'b0;
            rd_wen_q <= 1'b0;
            cause_q  <= '0;
        end else if (state == IDLE) begin
            if (mem_op && !lsu_flush) begin
                if (misal) begin
                    state   <= DONE;
                    trap_q  <= 1'b1;
                    cause_q <= lsu_store ? 4'd6 : 4'd4;
                end else begin
                    state    <= REQ;
                    addr_q   <= {a64[63:3], 3'b000};
                    wen_q    <= lsu_store;
                    strb_q   <= strb_n;
                    wdata_q  <= wdata_n;
                    width_q  <= lsu_width;
                    signed_q <= lsu_signed;
                    off_q    <= a64[2:0];
                end
            end
        end else if (state == REQ) begin
            if (dmem_gnt && lsu_flush) begin
                state <= IDLE;
            end else if (dmem_gnt) begin
                state    <= DONE;
                trap_q   <= dmem_err;
                cause_q  <= dmem_err ? (wen_q ? 4'd7 : 4'd5) : 4'd0;
                rd_wen_q <= !wen_q && !dmem_err;
                if (!wen_q && !dmem_err) rdata_q <= ld_ext[XLEN-1:0];
            end else if (lsu_flush) begin
                state <= DRAIN;
            end
        end else if (state == DRAIN) begin
            if (dmem_gnt) state <= IDLE;
        end else begin
            rd_wen_q <= 1'b0;
            if (lsu_new_instr || lsu_flush) begin
                state   <= IDLE;
                trap_q  <= 1'b0;
                cause_q <= 4'd0;
            end
        end
    end
endmodule
